// File: rtl/mcr3_rom_loader.sv
// MCR3 mono ROM download sequencer: routes ioctl bytes to SDRAM ports 1/2 and the tile BRAM.
// Optional checksum/overflow outputs are built when MCR3_ROM_LOADER_CHECKSUM_EN is defined.
module mcr3_rom_loader #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RST_HOLD   = 16'hFFFF
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        sg,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic        port1_req,
  input  logic        port1_ack,
  output logic [23:0] port1_a,
  output logic [7:0]  port1_d,
  output logic        port2_req,
  input  logic        port2_ack,
  output logic [23:0] port2_a,
  output logic [7:0]  port2_d,
  output logic        dl_wr,
  output logic [15:0] dl_addr,
  output logic [7:0]  dl_data,
  output logic        rom_loaded,
  output logic        core_reset
`ifdef MCR3_ROM_LOADER_CHECKSUM_EN
  ,
  output logic [15:0] dl_checksum,
  output logic [0:0]  dl_overflow
`endif
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] HIWAT   = (AW+1)'(FIFO_DEPTH - 1);

  localparam logic [1:0] R_MAIN = 2'd0;
  localparam logic [1:0] R_SPR  = 2'd1;
  localparam logic [1:0] R_GFX  = 2'd2;
  localparam logic [1:0] R_SND  = 2'd3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // ---------------- intake: classify and swizzle ----------------
  logic        wr_d = 1'b0;
  logic        dl_d = 1'b0;
  logic        wr_rise, dl_rise, dl_fall;
  logic [23:0] gfx1_off, snd_off;
  logic [23:0] s;
  logic [17:0] t;
  logic [15:0] g;
  logic [1:0]  in_rgn;
  logic [23:0] in_addr;

  assign wr_rise = ioctl_wr & ~wr_d;
  assign dl_rise = ioctl_download & ~dl_d;
  assign dl_fall = ~ioctl_download & dl_d;

  always_ff @(posedge clk_sys) begin
    wr_d <= ioctl_wr;
    dl_d <= ioctl_download;
  end

  always_comb begin
    gfx1_off = sg ? 24'h050000 : 24'h030000;
    snd_off  = sg ? 24'h058000 : 24'h038000;
    s        = 24'(ioctl_addr - 25'h0010000);
    t        = 18'(ioctl_addr - {1'b0, snd_off});
    g        = 16'(ioctl_addr - {1'b0, gfx1_off});
    in_rgn   = R_MAIN;
    in_addr  = ioctl_addr[23:0];
    if (ioctl_addr < 25'h0010000) begin
      in_rgn  = R_MAIN;
      in_addr = ioctl_addr[23:0];
    end else if (ioctl_addr < {1'b0, gfx1_off}) begin
      in_rgn  = R_SPR;
      in_addr = sg ? {s[23:18], s[15:0], s[17:16]} : {s[23:17], s[14:0], s[16:15]};
    end else if (ioctl_addr < {1'b0, snd_off}) begin
      in_rgn  = R_GFX;
      in_addr = {8'h00, g};
    end else begin
      in_rgn  = R_SND;
      in_addr = sg ? (snd_off + {6'h00, t[17], t[15:0], t[16]}) : ioctl_addr[23:0];
    end
  end

  // ---------------- byte FIFO ----------------
  logic [33:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic          push, accept, pop;
  logic [33:0]   head;
  logic [1:0]    head_rgn;
  logic [23:0]   head_addr;
  logic [7:0]    head_data;

  assign push      = wr_rise & ioctl_download & ~reset;
  assign accept    = push & (count != DEPTH_C);
  assign head      = mem[rptr];
  assign head_rgn  = head[33:32];
  assign head_addr = head[31:8];
  assign head_data = head[7:0];

  always_ff @(posedge clk_sys) begin
    if (accept) mem[wptr] <= {in_rgn, in_addr, ioctl_dout};
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (accept) wptr <= wptr + AW'(1);
      if (pop)    rptr <= rptr + AW'(1);
      case ({accept, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------- drain FSM ----------------
  logic [1:0] state;
  logic       cur_p2;
  logic       p1_req_q = 1'b0;
  logic       p2_req_q = 1'b0;
  logic       ack_ok;

  assign port1_req = p1_req_q;
  assign port2_req = p2_req_q;
  assign ack_ok    = cur_p2 ? (port2_ack == p2_req_q) : (port1_ack == p1_req_q);
  assign pop       = ~reset & (((state == S_ISSUE) & (head_rgn == R_GFX)) |
                               ((state == S_WAIT) & ack_ok));

  // req levels survive reset so the toggle handshake stays in step with the ack side;
  // ISSUE also waits for a stale ack left behind by a reset before toggling again.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state   <= S_IDLE;
      cur_p2  <= 1'b0;
      dl_wr   <= 1'b0;
      dl_addr <= '0;
      dl_data <= '0;
      port1_a <= '0;
      port1_d <= '0;
      port2_a <= '0;
      port2_d <= '0;
    end else begin
      dl_wr <= 1'b0;
      case (state)
        S_IDLE: if (count != '0) state <= S_ISSUE;
        S_ISSUE: begin
          if (head_rgn == R_GFX) begin
            dl_wr   <= 1'b1;
            dl_addr <= head_addr[15:0];
            dl_data <= head_data;
            state   <= S_IDLE;
          end else if (head_rgn == R_SPR) begin
            if (port2_ack == p2_req_q) begin
              port2_a  <= head_addr;
              port2_d  <= head_data;
              p2_req_q <= ~p2_req_q;
              cur_p2   <= 1'b1;
              state    <= S_WAIT;
            end
          end else begin
            if (port1_ack == p1_req_q) begin
              port1_a  <= head_addr;
              port1_d  <= head_data;
              p1_req_q <= ~p1_req_q;
              cur_p2   <= 1'b0;
              state    <= S_WAIT;
            end
          end
        end
        S_WAIT:  if (ack_ok) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) ioctl_wait <= 1'b0;
    else       ioctl_wait <= (count >= HIWAT) | (~ioctl_download & (state != S_IDLE));
  end

  // ---------------- load completion and core reset ----------------
  logic        loaded_q = 1'b0;
  logic        dl_pend  = 1'b0;
  logic [15:0] rst_cnt;

  assign rom_loaded = loaded_q;

  always_ff @(posedge clk_sys) begin
    if (dl_rise) begin
      loaded_q <= 1'b0;
      dl_pend  <= 1'b0;
    end else if (dl_fall) begin
      dl_pend <= 1'b1;
    end else if (dl_pend && !ioctl_download && count == '0 && state == S_IDLE) begin
      loaded_q <= 1'b1;
      dl_pend  <= 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset | ~loaded_q)  rst_cnt <= RST_HOLD;
    else if (rst_cnt != '0) rst_cnt <= rst_cnt - 16'd1;
    core_reset <= reset | ioctl_download | ~loaded_q | (rst_cnt == 16'd1);
  end

`ifdef MCR3_ROM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk_sys) begin
    if (reset | dl_rise) begin
      dl_checksum <= '0;
      dl_overflow <= '0;
    end else begin
      if (accept)          dl_checksum <= dl_checksum + {8'h00, ioctl_dout};
      if (push & ~accept)  dl_overflow <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/mcr3_rom_loader.md
Name: mcr3_rom_loader

Overview:
- Sequences the ROM download stream (ioctl byte writes) into the two SDRAM write ports and the on-chip background-tile download port of the MCR3 mono core.
- Classifies each byte by region, applies the per-board address swizzle, and buffers bytes in a small FIFO.
- Issues toggle-style requests to SDRAM ports 1 and 2, backpressures the HPS through ioctl_wait, and generates the core reset/rom_loaded sequence.
- Sits between hps_io and sdram/mcr3mono in the top level.

Parameters:
- FIFO_DEPTH, 4, byte-entry FIFO depth; power of 2, minimum 2.
- RST_HOLD, 16'hFFFF, clk_sys cycles from download end to the secondary reset pulse.

Ports:
- clk_sys  in  1  system clock (40 MHz)
- reset  in  1  synchronous, active-high; external reset (status[0] | button)
- sg  in  1  1 = Sounds Good board layout, 0 = Turbo Cheap Squeak layout
- ioctl_download  in  1  download in progress
- ioctl_wr  in  1  byte strobe; one byte per rising edge
- ioctl_addr  in  25  byte address
- ioctl_dout  in  8  byte data
- ioctl_wait  out  1  backpressure to HPS
- port1_req  out  1  toggle request, SDRAM port 1 (CPU/sound ROM)
- port1_ack  in  1  equals port1_req when the port is idle
- port1_a  out  24  byte address; bit 0 selects the byte lane
- port1_d  out  8  write byte
- port2_req/port2_ack/port2_a/port2_d  same as port 1, for SDRAM port 2 (sprites)
- dl_wr  out  1  one-cycle write strobe to the tile BRAM
- dl_addr  out  16  tile BRAM address
- dl_data  out  8  tile BRAM data
- rom_loaded  out  1  set once a download has completed and fully drained
- core_reset  out  1  reset to mcr3mono

Behaviour:
- Region bounds: gfx1_off = sg ? 0x50000 : 0x30000; snd_off = sg ? 0x58000 : 0x38000.
- Region MAIN, addr < 0x10000: port 1, port1_a = addr.
- Region SPR, 0x10000 ≤ addr < gfx1_off, with s = addr − 0x10000:
  - sg=1: port2_a = {s[23:18], s[15:0], s[17:16]}.
  - sg=0: port2_a = {s[23:17], s[14:0], s[16:15]}.
- Region GFX, gfx1_off ≤ addr < snd_off: dl port, dl_addr = (addr − gfx1_off)[15:0].
- Region SND, addr ≥ snd_off, with t = addr − snd_off:
  - sg=1: port1_a = snd_off + {t[17], t[15:0], t[16]}.
  - sg=0: port1_a = addr.
- Intake:
  - A byte is captured on the rising edge of ioctl_wr while ioctl_download=1; edge detection uses a registered copy of ioctl_wr.
  - Each captured byte is pushed as {region, mapped address, data}.
  - A push into a full FIFO is dropped and sets an internal overflow flag. This is an error case; the bench asserts it never occurs.
- ioctl_wait = 1 when FIFO count ≥ FIFO_DEPTH−1 or the drain FSM is not IDLE at download end. It is registered.
- Drain FSM states: IDLE, ISSUE, WAIT_ACK.
  - IDLE: if the FIFO is non-empty, go to ISSUE next cycle.
  - ISSUE, head region GFX: dl_wr=1 for exactly 1 cycle, pop, return to IDLE.
  - ISSUE, head region MAIN/SND/SPR: drive port*_a/port*_d from the head, toggle port*_req, go to WAIT_ACK.
  - WAIT_ACK: stay until port*_ack == port*_req, then pop and go to IDLE.
  - One request outstanding at a time. Address/data stay stable from ISSUE through the ack.
  - Minimum throughput: one GFX byte per 2 cycles; SDRAM bytes are limited by the ack.
- Reset sequence:
  - rom_loaded clears on reset=0? No: rom_loaded is not cleared by reset. It clears only at power-up init (0). It sets on the cycle the download has fallen and the FIFO is empty with the FSM in IDLE.
  - A new download start (ioctl_download rising) clears rom_loaded.
  - rst_cnt loads RST_HOLD while (reset | ~rom_loaded); otherwise it decrements to 0.
  - core_reset (registered) = reset | ioctl_download | ~rom_loaded | (rst_cnt == 1).
  - After load: core_reset deasserts, then pulses high for exactly 1 cycle RST_HOLD−1 cycles later.
- Reset values:
  - FIFO empty; FSM IDLE; port1_req = port2_req = 0.
  - dl_wr = 0; ioctl_wait = 0; core_reset = 1.
  - port*_a, port*_d, dl_addr, dl_data = 0.
- Reset mid-download: the FIFO is flushed and the FSM returns to IDLE. req signals keep their current level, so the toggle protocol is not desynchronised. Subsequent bytes are accepted normally.
- Simultaneous push and pop: allowed; count is unchanged.

Optional Feature:
- Macro: MCR3_ROM_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output dl_checksum [15:0], the wrapping sum of all accepted bytes.
  - Adds output dl_overflow [0:0], the sticky overflow flag.
  - Both clear at download start and on reset.
- When undefined: neither port exists, and no accumulator or flag logic is built.

Test Plan:
- sg=1, bytes at 0x00001=0xA5 and 0x58000=0x3C, ack echoed after 5 cycles -> port1_a = 0x000001, d = 0xA5; then port1_a = 0x058000, d = 0x3C; port1_req toggles twice; port 2 idle.
- sg=1, byte at 0x20000 (s = 0x10000) -> port2_a = 0x000001. sg=0, byte at 0x18000 (s = 0x8000) -> port2_a = 0x000001.
- sg=0, bytes at 0x30000..0x30003 = 1,2,3,4 -> four dl_wr pulses, dl_addr 0..3, data 1..4; no SDRAM requests.
- Ack withheld 40 cycles while 4 SDRAM bytes arrive every 4 cycles -> ioctl_wait high by the 3rd byte; no byte lost; all 4 acked in order.
- Download ends with 2 bytes pending -> rom_loaded rises only after the last ack. core_reset falls the next cycle, then is high for exactly 1 cycle RST_HOLD−1 cycles later (RST_HOLD = 16 in the bench).
- reset asserted during WAIT_ACK -> FIFO empty, FSM IDLE next cycle, port1_req level held; a following byte produces exactly one new toggle.
